muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. Consumes rs1/rs2 read data from the

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the issue/write-back logic and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, stall, done, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, stall, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and RV32M corner-case presets.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREP   = 2'd1;
    localparam logic [1:0] S_CALC   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        fn;
    logic [XLEN-1:0]   a_r;          // raw op_a, then multiplicand / dividend magnitude
    logic [XLEN-1:0]   b_r;          // raw op_b, then divisor magnitude
    logic [2*XLEN-1:0] acc;          // product, or quotient in the low half
    logic [XLEN-1:0]   rem_r;
    logic              sign_a;
    logic              sign_b;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_r;
    logic              done_r;

    // Operand signedness and magnitudes, evaluated on the raw operands in PREP.
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            div_overflow;
    logic [XLEN-1:0] preset_val;

    assign is_div   = fn[2];
    assign a_signed = (fn == F_MULH) | (fn == F_MULHSU) | (fn == F_DIV) | (fn == F_REM);
    assign b_signed = (fn == F_MULH) | (fn == F_DIV) | (fn == F_REM);
    assign neg_a    = a_signed & a_r[XLEN-1];
    assign neg_b    = b_signed & b_r[XLEN-1];
    assign mag_a    = neg_a ? -a_r : a_r;
    assign mag_b    = neg_b ? -b_r : b_r;

    assign div_by_zero  = is_div & (b_r == '0);
    assign div_overflow = ((fn == F_DIV) | (fn == F_REM)) & (a_r == INT_MIN) & (b_r == '1);

    // fn[1] selects REM/REMU over DIV/DIVU.
    always_comb begin
        // NOTE: assign a default before any branch so the block stays purely combinational (no latch).
        preset_val = '0;
        if (div_by_zero)
            preset_val = fn[1] ? a_r : '1;
        else if (div_overflow)
            preset_val = fn[1] ? '0 : INT_MIN;
    end

    // One multiply step: add multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, a_r} & {(XLEN+1){acc[0]}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // One restoring-divide step on an XLEN+1 bit working remainder.
    logic [XLEN:0]   rem_shift;
    logic            div_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    assign rem_shift = {rem_r, acc[XLEN-1]};
    assign div_ge    = rem_shift >= {1'b0, b_r};
    assign rem_next  = div_ge ? XLEN'(rem_shift - {1'b0, b_r}) : rem_shift[XLEN-1:0];
    assign quo_next  = {acc[XLEN-2:0], div_ge};

    // Sign fix-up and result selection for FINISH.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_val;

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = sign_a ? -rem_r : rem_r;

    always_comb begin
        final_val = quo_fix;
        if (special)
            final_val = special_val;
        else if (!is_div)
            final_val = (fn == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (fn[1])
            final_val = rem_fix;
    end

    // The done cycle is excluded so a start held through it lands one cycle later.
    logic accept;
    assign accept = bus.start & (state == S_IDLE) & ~done_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            fn          <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            rem_r       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            result_r    <= '0;
            rd_r        <= '0;
            done_r      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_r <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            fn    <= bus.funct3;
                            a_r   <= bus.op_a;
                            b_r   <= bus.op_b;
                            rd_r  <= bus.rd_in;
                            state <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        sign_a      <= neg_a;
                        sign_b      <= neg_b;
                        a_r         <= mag_a;
                        b_r         <= mag_b;
                        rem_r       <= '0;
                        cnt         <= '0;
                        acc         <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        special     <= div_by_zero | div_overflow;
                        special_val <= preset_val;
                        state       <= (div_by_zero | div_overflow) ? S_FINISH : S_CALC;
                    end
                    S_CALC: begin
                        if (is_div) begin
                            acc   <= {acc[2*XLEN-1:XLEN], quo_next};
                            rem_r <= rem_next;
                        end else begin
                            acc <= mul_next;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1))
                            state <= S_FINISH;
                    end
                    S_FINISH: begin
                        result_r <= final_val;
                        done_r   <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.stall  = (state != S_IDLE) | (bus.start & (state == S_IDLE));
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.rd_out = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, abort
// scenarios and randomized operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Architectural result computed with wide arithmetic on extended operands.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xs, xu, ys, yu, p;
        logic        ovf;
        xs  = {{32{a[31]}}, a};
        xu  = {32'b0, a};
        ys  = {{32{b[31]}}, b};
        yu  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            MUL:    begin p = xu * yu; return p[31:0];  end
            MULH:   begin p = xs * ys; return p[63:32]; end
            MULHSU: begin p = xs * yu; return p[63:32]; end
            MULHU:  begin p = xu * yu; return p[63:32]; end
            DIV:    if (b == 0) return 32'hFFFF_FFFF;
                    else if (ovf) return 32'h8000_0000;
                    else return 32'($signed(a) / $signed(b));
            DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
            REM:    if (b == 0) return a;
                    else if (ovf) return 32'h0;
                    else return 32'($signed(a) % $signed(b));
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
        if ((f3 == DIV || f3 == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    // Launch one op and follow it to done; poke_at > 0 raises a spurious
    // start with unrelated operands that many edges after acceptance.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int poke_at);
        int          edges;
        logic        stall_gap;
        logic [31:0] exp_val;
        int          exp_lat;
        exp_val   = ref_result(f3, a, b);
        exp_lat   = ref_latency(f3, a, b);
        stall_gap = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        #1 check({tag, ":stall_at_start"}, 32'(bus.stall), 32'd1);
        @(negedge clk);
        edges = 1;
        bus.start = 1'b0;
        bus.funct3 = 3'($urandom()); bus.op_a = $urandom(); bus.op_b = $urandom(); bus.rd_in = 5'($urandom());
        while (bus.done !== 1'b1 && edges < 100) begin
            if (bus.stall !== 1'b1) stall_gap = 1'b1;
            bus.start = (edges == poke_at);
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        check({tag, ":latency"}, 32'(edges - 1), 32'(exp_lat));
        check({tag, ":result"}, bus.result, exp_val);
        check({tag, ":rd_out"}, 32'(bus.rd_out), 32'(rd));
        check({tag, ":stall_while_busy"}, 32'(stall_gap), 32'd0);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, ":idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          dones;
        logic [31:0] prev_result;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
        bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;

        repeat (3) @(negedge clk);
        check("reset:busy",   32'(bus.busy),   32'd0);
        check("reset:done",   32'(bus.done),   32'd0);
        check("reset:stall",  32'(bus.stall),  32'd0);
        check("reset:result", bus.result,      32'd0);
        check("reset:rd_out", 32'(bus.rd_out), 32'd0);
        reset_n = 1'b1;

        run_op("mul_neg",      MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  0);
        check("mul_neg:golden", bus.result, 32'hFFFF_FFEB);
        run_op("mulhu_max",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  0);
        check("mulhu_max:golden", bus.result, 32'hFFFF_FFFE);
        run_op("mulh_min",     MULH,   32'h8000_0000, 32'h8000_0000, 5'd7,  0);
        check("mulh_min:golden", bus.result, 32'h4000_0000);
        run_op("mulhsu_m1",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  0);
        check("mulhsu_m1:golden", bus.result, 32'hFFFF_FFFF);
        run_op("div_neg",      DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  0);
        check("div_neg:golden", bus.result, 32'hFFFF_FFFD);
        run_op("rem_neg",      REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 0);
        check("rem_neg:golden", bus.result, 32'hFFFF_FFFF);
        run_op("divu",         DIVU,   32'd100,       32'd7,         5'd11, 0);
        check("divu:golden", bus.result, 32'd14);
        run_op("remu",         REMU,   32'd100,       32'd7,         5'd12, 0);
        check("remu:golden", bus.result, 32'd2);
        run_op("divu_zero",    DIVU,   32'd5,         32'd0,         5'd13, 0);
        run_op("rem_zero",     REM,    32'd5,         32'd0,         5'd14, 0);
        run_op("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        run_op("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);
        run_op("div_poke",     DIV,    32'hFFFF_FFF9, 32'd2,         5'd3,  10);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MUL; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd_in = 5'd21;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset:busy",   32'(bus.busy),   32'd0);
        check("midreset:result", bus.result,      32'd0);
        check("midreset:done",   32'(bus.done),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("midreset:no_done", 32'(dones), 32'd0);

        // Flush in the middle of a multiply keeps the previous result.
        run_op("pre_flush", DIVU, 32'd100, 32'd7, 5'd17, 0);
        prev_result = ref_result(DIVU, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MUL; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd18;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush:busy",   32'(bus.busy), 32'd0);
        check("flush:result", bus.result,    prev_result);
        check("flush:done",   32'(bus.done), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("flush:no_done", 32'(dones), 32'd0);
        check("flush:result_held", bus.result, prev_result);
        run_op("post_flush", MUL, 32'd3, 32'd4, 5'd19, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          poke;
            f3   = 3'($urandom_range(0, 7));
            a    = pick_operand();
            b    = pick_operand();
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, 5'($urandom()), poke);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
